// File: rtl/ifmap_dma_port.sv
// ifmap_dma_port: AXI-Stream <-> ping-pong buffer DMA port with independent load and store channels.
// Latency: load is a combinational pass-through; store issues its first read 1 cycle after start, first output 3 cycles after start.
// Backpressure: s_tready follows w_ready; store read issue is credit-limited so the 4-entry FIFO never holds more than 3 words.

module ifmap_dma_port #(
  parameter int ADDR_SIZE  = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  // load channel
  input  logic                  start_load,
  input  logic [ADDR_SIZE-1:0]  load_base,
  input  logic [ADDR_SIZE:0]    load_len,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [ADDR_SIZE-1:0]  w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  output logic                  w_last,
  input  logic                  w_ready,
  // store channel
  input  logic                  start_store,
  input  logic [ADDR_SIZE-1:0]  store_base,
  input  logic [ADDR_SIZE:0]    store_len,
  output logic                  r_valid,
  output logic [ADDR_SIZE-1:0]  r_addr,
  input  logic                  r_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  // status
  output logic                  load_busy,
  output logic                  store_busy,
  output logic                  load_done,
  output logic                  store_done,
  output logic                  err_len
);

  localparam int LW = ADDR_SIZE + 1;

  // ---------------------------------------------------------------- load
  typedef enum logic [1:0] {L_IDLE, L_RUN, L_DONE} lstate_t;

  lstate_t              lstate;
  logic [ADDR_SIZE-1:0] lbase;
  logic [LW-1:0]        llen;
  logic [LW-1:0]        lcnt;
  logic                 err_q;
  logic                 l_run;
  logic                 l_beat;
  logic                 l_is_last;

  // Beat qualification: a beat moves only while running and both sides agree.
  always_comb begin
    l_run     = (lstate == L_RUN);
    l_is_last = (lcnt == llen - LW'(1));
    l_beat    = l_run && s_tvalid && w_ready;
  end

  // Stream-to-write pass-through; everything is forced low outside L_RUN.
  assign s_tready  = l_run & w_ready;
  assign w_valid   = l_run & s_tvalid;
  assign w_data    = l_run ? s_tdata : '0;
  assign w_addr    = l_run ? (lbase + lcnt[ADDR_SIZE-1:0]) : '0;
  assign w_last    = l_run & l_is_last;
  assign load_busy = (lstate != L_IDLE);
  assign load_done = (lstate == L_DONE);
  assign err_len   = err_q;

  // Load FSM: the programmed length decides the end; tlast only feeds err_len.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lstate <= L_IDLE;
      lbase  <= '0;
      llen   <= '0;
      lcnt   <= '0;
      err_q  <= 1'b0;
    end else begin
      case (lstate)
        L_IDLE: begin
          if (start_load) begin
            lbase  <= load_base;
            llen   <= load_len;
            lcnt   <= '0;
            err_q  <= 1'b0;
            lstate <= (load_len == '0) ? L_DONE : L_RUN;
          end
        end
        L_RUN: begin
          if (l_beat) begin
            lcnt <= lcnt + LW'(1);
            if (s_tlast != l_is_last) begin
              err_q <= 1'b1;
            end
            if (l_is_last) begin
              lstate <= L_DONE;
            end
          end
        end
        L_DONE:  lstate <= L_IDLE;
        default: lstate <= L_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- store
  typedef enum logic {S_IDLE, S_RUN} sstate_t;

  sstate_t              sstate;
  logic [ADDR_SIZE-1:0] sbase;
  logic [LW-1:0]        slen;
  logic [LW-1:0]        icnt;
  logic [LW-1:0]        ocnt;
  logic                 inflight;
  logic                 sdone;
  logic [DATA_WIDTH-1:0] fifo_mem [0:3];
  logic [1:0]           wptr;
  logic [1:0]           rptr;
  logic [2:0]           fifo_cnt;
  logic [2:0]           credit;
  logic                 s_run;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 o_last;

  // Read issue is gated by credits: buffered words plus the read in flight must stay below 3.
  always_comb begin
    s_run  = (sstate == S_RUN);
    credit = fifo_cnt + {2'b00, inflight};
    issue  = s_run && (icnt < slen) && r_ready && (credit < 3'd3);
    push   = inflight;
    pop    = (fifo_cnt != 3'd0) && m_tready;
    o_last = (ocnt == slen - LW'(1));
  end

  assign r_valid    = issue;
  assign r_addr     = s_run ? (sbase + icnt[ADDR_SIZE-1:0]) : '0;
  assign m_tvalid   = (fifo_cnt != 3'd0);
  assign m_tdata    = m_tvalid ? fifo_mem[rptr] : '0;
  assign m_tlast    = m_tvalid & o_last;
  assign store_busy = s_run;
  assign store_done = sdone;

  // Store FSM with FIFO bookkeeping; the final pop ends the transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sstate   <= S_IDLE;
      sbase    <= '0;
      slen     <= '0;
      icnt     <= '0;
      ocnt     <= '0;
      inflight <= 1'b0;
      sdone    <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      sdone    <= 1'b0;
      inflight <= issue;
      case (sstate)
        S_IDLE: begin
          if (start_store) begin
            sbase    <= store_base;
            slen     <= store_len;
            icnt     <= '0;
            ocnt     <= '0;
            inflight <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
            if (store_len == '0) begin
              sdone <= 1'b1;
            end else begin
              sstate <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            icnt <= icnt + LW'(1);
          end
          if (push) begin
            wptr <= wptr + 2'd1;
          end
          if (pop) begin
            rptr <= rptr + 2'd1;
            ocnt <= ocnt + LW'(1);
          end
          fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
          if (pop && o_last) begin
            sdone  <= 1'b1;
            sstate <= S_IDLE;
          end
        end
        default: sstate <= S_IDLE;
      endcase
    end
  end

  // FIFO storage captures the buffer read data one cycle after each request.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr] <= r_data;
    end
  end

endmodule

// File: tb/tb_ifmap_dma_port.sv
// Bench for ifmap_dma_port: buffer read model plus scoreboards for writes, read addresses and output beats.
// Inputs are driven 1 time unit after the rising edge, outputs are observed on the falling edge.
// Each scenario task drives its own stimulus and checks timing/status inline.

module tb_ifmap_dma_port;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start_load = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_len = '0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_last;
  logic          w_ready = 1'b0;
  logic          start_store = 1'b0;
  logic [AW-1:0] store_base = '0;
  logic [AW:0]   store_len = '0;
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic          r_ready = 1'b1;
  logic [DW-1:0] r_data = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic          load_busy, store_busy, load_done, store_done, err_len;

  ifmap_dma_port #(.ADDR_SIZE(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .start_load(start_load), .load_base(load_base), .load_len(load_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready),
    .start_store(start_store), .store_base(store_base), .store_len(store_len),
    .r_valid(r_valid), .r_addr(r_addr), .r_ready(r_ready), .r_data(r_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .load_busy(load_busy), .store_busy(store_busy), .load_done(load_done),
    .store_done(store_done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  logic [94:0] all_out;
  assign all_out = {s_tready, w_addr, w_data, w_valid, w_last, r_valid, r_addr, m_tdata,
                    m_tvalid, m_tlast, load_busy, store_busy, load_done, store_done, err_len};

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_rv = 0;

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic last;} wr_t;
  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  wr_t           wq[$];
  beat_t         mq[$];
  logic [AW-1:0] aq[$];

  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  function automatic logic [DW-1:0] src_f(input logic [AW-1:0] base, input int i);
    return {4'hA, 6'h00, base, 12'(i)};
  endfunction

  // Buffer read port model: data appears one cycle after the request.
  always @(posedge clk) begin
    if (r_valid) r_data <= ram_f(r_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard pops for every handshake seen this cycle.
  task automatic monitor();
    wr_t           we;
    beat_t         me;
    logic [AW-1:0] ae;
    if (rstn && w_valid && w_ready) begin
      n_wr++;
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", w_addr, w_data);
      end else begin
        we = wq.pop_front();
        if ({w_addr, w_data, w_last} !== we) begin
          errors++;
          $display("FAIL wr_beat: got addr=%h data=%h last=%b, required addr=%h data=%h last=%b",
                   w_addr, w_data, w_last, we.addr, we.data, we.last);
        end
      end
    end
    if (rstn && r_valid) begin
      n_rv++;
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got r_addr=%h, required no read", r_addr);
      end else begin
        ae = aq.pop_front();
        if (r_addr !== ae) begin
          errors++;
          $display("FAIL rd_addr: got %h, required %h", r_addr, ae);
        end
      end
    end
    if (rstn && m_tvalid && m_tready) begin
      checks++;
      if (mq.size() == 0) begin
        errors++;
        $display("FAIL m_unexpected: got data=%h, required no beat", m_tdata);
      end else begin
        me = mq.pop_front();
        if ({m_tdata, m_tlast} !== me) begin
          errors++;
          $display("FAIL m_beat: got data=%h last=%b, required data=%h last=%b",
                   m_tdata, m_tlast, me.data, me.last);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) tick();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL idle_outputs: got %h, required 0", all_out);
    end
  endtask

  // wr_pat 0: w_ready held high; 1: w_ready toggles 1,0,1,0...
  task automatic test_load(input string nm, input logic [AW-1:0] base, input int len,
                           input int tlast_at, input int wr_pat, input logic exp_err);
    int   beat;
    int   cyc;
    int   nw0;
    logic acc;
    beat = 0;
    cyc  = 0;
    nw0  = n_wr;
    for (int i = 0; i < len; i++) wq.push_back({base + AW'(i), src_f(base, i), i == len - 1});
    @(posedge clk); #1;
    load_base  = base;
    load_len   = (AW + 1)'(len);
    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    while (beat < len && cyc < 200) begin
      w_ready  = (wr_pat == 0) ? 1'b1 : ((cyc % 2) == 0);
      s_tvalid = 1'b1;
      s_tdata  = src_f(base, beat);
      s_tlast  = (beat == tlast_at);
      start_load = (cyc == 1);
      load_base  = ~base;
      load_len   = 11'd3;
      tick();
      checks++;
      if (s_tready !== w_ready) begin
        errors++;
        $display("FAIL %s s_tready: got %b, required %b", nm, s_tready, w_ready);
      end
      if (cyc == 0) begin
        checks++;
        if (err_len !== 1'b0) begin
          errors++;
          $display("FAIL %s err_clear: got %b, required 0", nm, err_len);
        end
      end
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (acc) beat++;
      cyc++;
    end
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    start_load = 1'b0;
    checks++;
    if (beat != len) begin
      errors++;
      $display("FAIL %s timeout: got %0d beats, required %0d", nm, beat, len);
    end
    tick();
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL %s load_done: got %b, required 1", nm, load_done);
    end
    @(posedge clk); #1;
    tick();
    checks++;
    if ({load_done, load_busy, err_len} !== {1'b0, 1'b0, exp_err}) begin
      errors++;
      $display("FAIL %s end_status: got done/busy/err=%b%b%b, required 00%b",
               nm, load_done, load_busy, err_len, exp_err);
    end
    checks++;
    if ((n_wr - nw0) != len || wq.size() != 0) begin
      errors++;
      $display("FAIL %s write_count: got %0d (left %0d), required %0d", nm, n_wr - nw0, wq.size(), len);
    end
  endtask

  task automatic test_err_hold();
    repeat (5) tick();
    checks++;
    if (err_len !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: got %b, required 1", err_len);
    end
  endtask

  // rr_pat 1 toggles r_ready; stall window holds m_tready low for stall_len cycles from stall_at.
  task automatic test_store(input string nm, input logic [AW-1:0] base, input int len,
                            input int stall_at, input int stall_len, input int rr_pat);
    int   cyc;
    int   nrv0;
    int   gaps;
    logic done;
    logic prev_last;
    logic in_stall;
    cyc = 0; gaps = 0; done = 1'b0; prev_last = 1'b0;
    nrv0 = n_rv;
    for (int i = 0; i < len; i++) begin
      aq.push_back(base + AW'(i));
      mq.push_back({ram_f(base + AW'(i)), i == len - 1});
    end
    m_tready = 1'b1;
    r_ready  = 1'b1;
    @(posedge clk); #1;
    store_base  = base;
    store_len   = (AW + 1)'(len);
    start_store = 1'b1;
    @(posedge clk); #1;
    start_store = 1'b0;
    while (!done && cyc < 300) begin
      in_stall    = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
      m_tready    = !in_stall;
      r_ready     = (rr_pat == 0) ? 1'b1 : ((cyc % 3) != 1);
      start_store = (cyc == 2);
      store_base  = ~base;
      tick();
      if (rr_pat == 0 && len > 0 && cyc < 3) begin
        checks++;
        if ((cyc == 0 && r_valid !== 1'b1) || (cyc == 1 && m_tvalid !== 1'b0) ||
            (cyc == 2 && m_tvalid !== 1'b1)) begin
          errors++;
          $display("FAIL %s start_timing: cyc=%0d got r_valid=%b m_tvalid=%b", nm, cyc, r_valid, m_tvalid);
        end
      end
      if (in_stall && cyc >= stall_at + 2) begin
        checks++;
        if (r_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_credit: cyc=%0d got r_valid=%b, required 0", nm, cyc, r_valid);
        end
      end
      if (rr_pat == 0 && cyc >= 2 && m_tready && !m_tvalid && mq.size() > 0) gaps++;
      if (store_done) begin
        done = 1'b1;
        checks++;
        if (prev_last !== (len > 0) || mq.size() != 0 || store_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_pulse: got prev_tlast=%b left=%0d busy=%b, required %b 0 0",
                   nm, prev_last, mq.size(), store_busy, len > 0);
        end
      end
      prev_last = m_tvalid && m_tready && m_tlast;
      @(posedge clk); #1;
      cyc++;
    end
    start_store = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got no store_done, required one within 300 cycles", nm);
    end
    checks++;
    if ((n_rv - nrv0) != len || gaps != 0) begin
      errors++;
      $display("FAIL %s issue_rate: got %0d reads %0d gaps, required %0d reads 0 gaps", nm, n_rv - nrv0, gaps, len);
    end
    tick();
    checks++;
    if (store_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: got %b, required 0", nm, store_done);
    end
  endtask

  task automatic test_reset_mid_store();
    for (int i = 0; i < 20; i++) begin
      aq.push_back(AW'(10'h080 + i));
      mq.push_back({ram_f(AW'(10'h080 + i)), i == 19});
    end
    m_tready = 1'b0;
    r_ready  = 1'b1;
    @(posedge clk); #1;
    store_base  = 10'h080;
    store_len   = 11'd20;
    start_store = 1'b1;
    @(posedge clk); #1;
    start_store = 1'b0;
    repeat (5) tick();
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got %h, required 0", all_out);
    end
    tick();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL rst_mid_held: got %h, required 0", all_out);
    end
    aq.delete();
    mq.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    test_store("st_after_rst", 10'h3FF, 2, -1, 0, 0);
  endtask

  task automatic test_concurrent();
    int   beat;
    int   cyc;
    logic ld_seen;
    logic st_seen;
    logic acc;
    beat = 0; cyc = 0; ld_seen = 1'b0; st_seen = 1'b0;
    for (int i = 0; i < 5; i++) wq.push_back({AW'(10'h3FE + i), src_f(10'h3FE, i), i == 4});
    for (int i = 0; i < 7; i++) begin
      aq.push_back(AW'(10'h3FD + i));
      mq.push_back({ram_f(AW'(10'h3FD + i)), i == 6});
    end
    @(posedge clk); #1;
    load_base = 10'h3FE; load_len = 11'd5; start_load = 1'b1;
    store_base = 10'h3FD; store_len = 11'd7; start_store = 1'b1;
    w_ready = 1'b1; m_tready = 1'b1; r_ready = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0; start_store = 1'b0;
    while (!(ld_seen && st_seen) && cyc < 100) begin
      s_tvalid = (beat < 5);
      s_tdata  = src_f(10'h3FE, beat);
      s_tlast  = (beat == 4);
      tick();
      if (load_done) ld_seen = 1'b1;
      if (store_done) st_seen = 1'b1;
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (acc) beat++;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checks++;
    if (!ld_seen || !st_seen || wq.size() != 0 || mq.size() != 0 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL concurrent: got ld_done=%b st_done=%b wq=%0d mq=%0d err=%b, required 1 1 0 0 0",
               ld_seen, st_seen, wq.size(), mq.size(), err_len);
    end
  endtask

  initial begin
    test_reset();
    test_load("ld8", 10'h3FC, 8, 7, 0, 1'b0);
    test_load("ld_bp", 10'h040, 4, 3, 1, 1'b0);
    test_load("ld_err", 10'h100, 4, 2, 0, 1'b1);
    test_err_hold();
    test_reset_mid_store();
    test_load("ld_zero", 10'h055, 0, -1, 0, 1'b0);
    test_store("st6", 10'h010, 6, -1, 0, 0);
    test_store("st_stall", 10'h3F8, 16, 4, 10, 0);
    test_store("st_rready", 10'h200, 9, -1, 0, 1);
    test_store("st_zero", 10'h000, 0, -1, 0, 0);
    test_concurrent();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
